// File: rtl/alu_exec_mc_if.sv
// Request/response bus between the decode stage, the execute unit and the memory/writeback stages.
// A request transfers on the rising edge where in_valid && in_ready, and a result transfers on the edge
// where out_valid && out_ready; the sender holds its payload stable until that edge.
interface alu_exec_mc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_op;
  logic [1:0]       alu_funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, alu_op, alu_funct, a, b, out_ready,
    input  in_ready, out_valid, result, zero, ovf, err
  );

  modport slave (
    input  in_valid, alu_op, alu_funct, a, b, out_ready,
    output in_ready, out_valid, result, zero, ovf, err
  );
endinterface

// File: rtl/alu_exec_mc.sv
// Execute unit: decodes {alu_op, alu_funct}, registers the ALU result and flags, and runs
// shifts/rotates iteratively one bit per cycle while stalling the upstream stage.
module alu_exec_mc #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_mc_if.slave   bus,
  output logic           dbg_state
);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         shift_kind;
  logic               out_valid_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               ovf_q;
  logic               err_q;

  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   not_a;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_ovf;
  logic               alu_err;
  logic               is_shift;
  logic [WIDTH-1:0]   shift_next;

  assign shamt        = bus.b[SHAMT_W-1:0];
  assign not_a        = ~bus.a;
  assign bus.in_ready = (state == IDLE) && (!out_valid_q || bus.out_ready) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_err  = 1'b0;
    is_shift = 1'b0;
    casez ({bus.alu_op, bus.alu_funct})
      7'b11000_?? : alu_res = bus.b;
      7'b11011_00,
      7'b01000_?? : begin
        alu_res = bus.a + bus.b;
        alu_ovf = (bus.a[MSB] == bus.b[MSB]) && (alu_res[MSB] != bus.a[MSB]);
      end
      // Subtraction is b - a, formed as b + ~a + 1; overflow looks at the inverted operand.
      7'b11011_01,
      7'b10001_?? : begin
        alu_res = bus.b + not_a + WIDTH'(1);
        alu_ovf = (not_a[MSB] == bus.b[MSB]) && (alu_res[MSB] != bus.b[MSB]);
      end
      7'b11011_10 : alu_res = bus.a ^ bus.b;
      7'b11011_11 : alu_res = bus.a & ~bus.b;
      // A zero shift amount completes immediately with the operand unchanged.
      7'b11010_?? : begin
        alu_res  = bus.a;
        is_shift = 1'b1;
      end
      7'b00000_?? : alu_res = '0;
      default     : alu_err = 1'b1;
    endcase
  end

  always_comb begin
    shift_next = work;
    case (shift_kind)
      2'b00:   shift_next = {work[MSB-1:0], work[MSB]};
      2'b01:   shift_next = {work[MSB-1:0], 1'b0};
      2'b10:   shift_next = {work[0], work[MSB:1]};
      default: shift_next = {1'b0, work[MSB:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      shift_kind  <= 2'b00;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              work        <= bus.a;
              cnt         <= shamt;
              shift_kind  <= bus.alu_funct;
              out_valid_q <= 1'b0;
              state       <= SHIFT;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= alu_res;
              zero_q      <= (alu_res == '0);
              ovf_q       <= alu_ovf;
              err_q       <= alu_err;
            end
          end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        SHIFT: begin
          work <= shift_next;
          cnt  <= cnt - SHAMT_W'(1);
          if (cnt == SHAMT_W'(1)) begin
            state       <= IDLE;
            out_valid_q <= 1'b1;
            result_q    <= shift_next;
            zero_q      <= (shift_next == '0);
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_alu_exec_mc.sv
// Bench for alu_exec_mc: directed boundary cases followed by randomized traffic, checked against
// an arithmetic reference model through an expected-result queue.
module tb_alu_exec_mc;
  localparam int W  = 16;
  localparam int EW = W + 3;

  logic clk;
  logic rst;
  logic dbg_state;
  alu_exec_mc_if #(.WIDTH(W)) bus ();

  alu_exec_mc #(.WIDTH(W), .SHAMT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: result and flags straight from signed/unsigned arithmetic; packed {err, ovf, zero, result}.
  function automatic logic [EW-1:0] model(input logic [4:0] op, input logic [1:0] f,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, s, k;
    logic [31:0] a32;
    logic [W-1:0] r;
    logic e, o;
    r = '0; e = 1'b0; o = 1'b0;
    sa = int'($signed(a));
    sb = int'($signed(b));
    a32 = {16'h0, a};
    k = int'(b[3:0]);
    if (op == 5'b11000) r = b;
    else if ((op == 5'b11011 && f == 2'd0) || op == 5'b01000) begin
      s = sa + sb; r = s[W-1:0]; o = (s > 32767) || (s < -32768);
    end else if ((op == 5'b11011 && f == 2'd1) || op == 5'b10001) begin
      s = sb - sa; r = s[W-1:0]; o = (s > 32767) || (s < -32768);
    end else if (op == 5'b11011 && f == 2'd2) r = a ^ b;
    else if (op == 5'b11011 && f == 2'd3) r = a & ~b;
    else if (op == 5'b11010) begin
      case (f)
        2'd0:    r = W'((a32 << k) | (a32 >> (W - k)));
        2'd1:    r = W'(a32 << k);
        2'd2:    r = W'((a32 >> k) | (a32 << (W - k)));
        default: r = W'(a32 >> k);
      endcase
    end else if (op == 5'b00000) r = '0;
    else e = 1'b1;
    return {e, o, (r == '0), r};
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input logic [4:0] op, input logic [1:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int waited);
    bit done;
    bus.alu_op = op; bus.alu_funct = f; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    waited = 0;
    done = 1'b0;
    while (!done && waited < 100) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(model(op, f, a, b));
        done = 1'b1;
      end else waited++;
      @(posedge clk); #1;
    end
    if (!done) check("issue_timeout", 32'd1, 32'd0);
    bus.in_valid = 1'b0;
  endtask

  // Expects k busy cycles then a completed result; ends at posedge+1.
  task automatic wait_done(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      check("busy_out_valid", 32'(bus.out_valid), 32'd0);
      check("busy_state", 32'(dbg_state), 32'd1);
    end
    @(negedge clk);
    check("done_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard plus hold-stability monitor.
  logic [EW-1:0] prev_obs;
  logic          prev_stall = 1'b0;
  always @(negedge clk) begin
    logic [EW-1:0] obs;
    obs = {bus.err, bus.ovf, bus.zero, bus.result};
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold", 32'({bus.out_valid, obs}), 32'({1'b1, prev_obs}));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
        else check("result", 32'(obs), 32'(exp_q.pop_front()));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_obs = obs;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int w;
    logic [4:0] op;
    logic [4:0] op_tab[8];
    op_tab = '{5'b11000, 5'b11011, 5'b11011, 5'b01000, 5'b10001, 5'b11010, 5'b11010, 5'b00000};
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.alu_op = '0; bus.alu_funct = '0; bus.a = '0; bus.b = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flags", 32'({bus.err, bus.ovf, bus.zero, bus.result}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // ADD overflow into the sign bit
    issue(5'b11011, 2'd0, 16'h7FFF, 16'h0001, w);
    wait_done(0);

    // SUB then SUBI back-to-back
    issue(5'b11011, 2'd1, 16'd3, 16'd5, w);
    issue(5'b10001, 2'd0, 16'd5, 16'd5, w);
    check("b2b_accept_wait", 32'(w), 32'd0);
    wait_done(0);

    // ROL by 4, SRL by 15, SRL by 0
    issue(5'b11010, 2'd0, 16'h8001, 16'd4, w);
    wait_done(4);
    issue(5'b11010, 2'd3, 16'h8000, 16'd15, w);
    wait_done(15);
    issue(5'b11010, 2'd3, 16'hA5C3, 16'h0010, w);
    wait_done(0);

    // XOR result held under backpressure, then released with a new op on the same edge
    bus.out_ready = 1'b0;
    issue(5'b11011, 2'd2, 16'h1234, 16'hFF00, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    issue(5'b11011, 2'd3, 16'hF0F0, 16'h3C3C, w);
    check("release_accept_wait", 32'(w), 32'd0);
    wait_done(0);

    // Reset during the second SHIFT cycle of ROR by 8
    issue(5'b11010, 2'd2, 16'h1234, 16'd8, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready_after", 32'(bus.in_ready), 32'd1);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;

    // Unsupported op completes with err set
    issue(5'b11111, 2'd0, 16'h5555, 16'h1111, w);
    wait_done(0);

    // Randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [W-1:0] ra, rb;
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : op_tab[$urandom_range(0, 7)];
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom);
      if ($urandom_range(0, 5) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      issue(op, 2'($urandom), ra, rb, w);
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
